fetch_icache_responder: RTL and testbench
=========================================

Name: fetch_icache_responder

Overview:
- Memory-side responder for the fetch stage's instruction request. Fetch drives `pc` and `imemREN`; this block returns `imemload` and `ihit`.
- Direct-mapped, one word per frame. Misses are filled from the backing memory over an `iREN`/`iwait` handshake.
- Sits between the fetch/branch stage and the memory arbiter.

Parameters:
- SETS, 16, number of frames (power of 2, >=2).
- WORD_W, 32, instruction and address width (word_t).
- IDX_W, $clog2(SETS), index width (derived, not overridable).

Ports:
- CLK  input  1  clock.
- nRST  input  1  asynchronous active-low reset.
- imemREN  input  1  fetch requests the instruction at `pc`.
- pc  input  WORD_W  fetch byte address.
- flush  input  1  invalidate all frames (fence or self-modifying code).
- ihit  output  1  `imemload` is valid for the current `pc` this cycle.
- imemload  output  WORD_W  instruction word.
- iREN  output  1  read request to the memory arbiter.
- iaddr  output  WORD_W  word-aligned memory read address.
- iwait  input  1  memory busy; low means `iload` is valid this cycle.
- iload  input  WORD_W  memory read data.

Behaviour:
- Address split:
  - `pc[1:0]` ignored.
  - index = `pc[IDX_W+1:2]`.
  - tag = `pc[WORD_W-1:IDX_W+2]`.
  - `iaddr` = {latched pc[WORD_W-1:2], 2'b00}.
- Storage per frame: valid bit, tag, data word, all registered. Only valid bits are reset.
- Reset (nRST low, asynchronous):
  - All valid bits cleared; state = IDLE.
  - Latched address and abort flag cleared.
  - `ihit`=0, `imemload`=0, `iREN`=0, `iaddr`=0.
- IDLE state:
  - Hit condition: `imemREN` && valid[idx] && tag match && !`flush`.
  - On hit: `ihit`=1 and `imemload`=data[idx] in the same cycle (combinational, zero-cycle hit latency).
  - On miss (`imemREN` && !hit && !`flush`): latch `pc`, clear abort; next state MISS. `ihit`=0.
  - `imemREN`=0: `ihit`=0, `imemload`=0.
- MISS state:
  - `iREN`=1 and `iaddr` = latched address, held stable until `iwait`=0.
  - Fetch must hold `pc` while `ihit`=0.
  - Abort condition: `flush`=1, or `imemREN`=0, or `pc` differs from the latched address in any cycle of MISS. The abort flag is sticky until the transaction ends.
  - When `iwait`=0 and not aborted: write {valid=1, tag, iload} to the frame; `ihit`=1; `imemload`=`iload` (fill forwarding); next state IDLE.
  - When `iwait`=0 and aborted: no frame write, `ihit`=0, next state IDLE.
  - A request is never dropped mid-handshake: `iREN` stays high until `iwait`=0, even after abort.
- Flush:
  - Clears all valid bits at the next edge.
  - A fill completing in the same cycle as a flush is not written.
  - Any hit in a flush cycle is suppressed.
- Replacement: a fill overwrites frame[idx] unconditionally (direct-mapped).
- Latency:
  - Hit: 0 cycles.
  - Miss: 1 cycle to enter MISS + memory wait cycles; `ihit` asserts in the `iwait`=0 cycle.
- Back-to-back: a fill cycle returns to IDLE, so a new miss can enter MISS on the following edge (one IDLE cycle minimum between transactions).

Optional Feature:
- Macro ICACHE_STATS_EN.
- Defined: adds outputs `hit_count` and `miss_count` (32-bit each).
  - Reset to 0 on nRST; saturate at 32'hFFFF_FFFF.
  - `hit_count` increments on each IDLE-state hit cycle.
  - `miss_count` increments on each IDLE→MISS transition.
  - Fill-forward cycles are counted as misses only.
  - Unaffected by `flush`.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Reset, then `imemREN`=1, `pc`=0x0000_0040 → `ihit`=0; next cycle `iREN`=1, `iaddr`=0x40. Memory gives `iwait`=1 for 3 cycles then `iwait`=0, `iload`=0x1234_5678 → `ihit`=1, `imemload`=0x1234_5678 that cycle. Re-request 0x40 → `ihit`=1 in the same cycle, `iREN`=0.
- Conflict: fill 0x40, then `pc`=0x80 (same index, SETS=16) → miss, refill. Then 0x40 → miss again.
- Flush: with 0x40 cached, pulse `flush` → `ihit`=0 that cycle. Next request to 0x40 → miss.
- Abort: miss on 0x100, raise `flush` while `iwait`=1 → `iREN` held until `iwait`=0, `ihit` stays 0. A later request to 0x100 misses.
- Async reset mid-MISS: drop nRST between edges → `iREN`=0 immediately; state IDLE; all frames invalid.
- With ICACHE_STATS_EN: 1 miss + 4 hits on 0x40 → `miss_count`=1, `hit_count`=4.

Source files
------------

// File: rtl/fetch_icache_responder.sv
// Direct-mapped, one-word-per-frame instruction cache responder with zero-cycle hits and iREN/iwait miss fill.
// Optional ICACHE_STATS_EN macro adds saturating hit_count/miss_count outputs.
module fetch_icache_responder #(
  parameter int SETS   = 16,
  parameter int WORD_W = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              imemREN,
  input  logic [WORD_W-1:0] pc,
  input  logic              flush,
  output logic              ihit,
  output logic [WORD_W-1:0] imemload,
  output logic              iREN,
  output logic [WORD_W-1:0] iaddr,
  input  logic              iwait,
`ifdef ICACHE_STATS_EN
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count,
`endif
  input  logic [WORD_W-1:0] iload
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = WORD_W - IDX_W - 2;

  typedef enum logic {IDLE, MISS} state_t;

  state_t            r_state, w_next_state;
  logic [SETS-1:0]   r_valid;
  logic [TAG_W-1:0]  r_tag  [SETS];
  logic [WORD_W-1:0] r_data [SETS];
  logic [WORD_W-1:0] r_addr;
  logic              r_abort;

  logic [IDX_W-1:0]  w_idx, w_fill_idx;
  logic [TAG_W-1:0]  w_tag, w_fill_tag;
  logic              w_hit, w_miss_start, w_aborted, w_fill;

  assign w_idx      = pc[IDX_W+1:2];
  assign w_tag      = pc[WORD_W-1:IDX_W+2];
  assign w_fill_idx = r_addr[IDX_W+1:2];
  assign w_fill_tag = r_addr[WORD_W-1:IDX_W+2];

  assign w_hit        = (r_state == IDLE) && imemREN && r_valid[w_idx] &&
                        (r_tag[w_idx] == w_tag) && !flush;
  assign w_miss_start = (r_state == IDLE) && imemREN && !w_hit && !flush;
  // Full-pc compare: any change of the requested address while waiting abandons the fill.
  assign w_aborted    = r_abort || flush || !imemREN || (pc != r_addr);
  assign w_fill       = (r_state == MISS) && !iwait && !w_aborted;

  assign iaddr = {r_addr[WORD_W-1:2], 2'b00};

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    ihit         = 1'b0;
    imemload     = '0;
    iREN         = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_hit) begin
          ihit     = 1'b1;
          imemload = r_data[w_idx];
        end else if (w_miss_start) begin
          w_next_state = MISS;
        end
      end
      MISS: begin
        iREN = 1'b1;
        if (!iwait) begin
          w_next_state = IDLE;
          if (w_fill) begin
            ihit     = 1'b1;
            imemload = iload;
          end
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_valid <= '0;
      r_addr  <= '0;
      r_abort <= 1'b0;
    end else begin
      if (flush) begin
        r_valid <= '0;
      end else if (w_fill) begin
        r_valid[w_fill_idx] <= 1'b1;
      end
      if (w_miss_start) begin
        r_addr  <= pc;
        r_abort <= 1'b0;
      end else if (r_state == MISS) begin
        r_abort <= w_aborted;
      end
    end
  end

  // Tag and data storage carry no reset; only the valid bits qualify them.
  always_ff @(posedge CLK) begin
    if (w_fill) begin
      r_tag[w_fill_idx]  <= w_fill_tag;
      r_data[w_fill_idx] <= iload;
    end
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] r_hit_count, r_miss_count;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else begin
      if (w_hit && (r_hit_count != 32'hFFFF_FFFF)) begin
        r_hit_count <= r_hit_count + 32'd1;
      end
      if (w_miss_start && (r_miss_count != 32'hFFFF_FFFF)) begin
        r_miss_count <= r_miss_count + 32'd1;
      end
    end
  end

  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;
`endif

endmodule

// File: tb/tb_fetch_icache_responder.sv
// Directed bench for fetch_icache_responder: scoreboard of expected fill/hit data plus immediate-assert checks.
// Covers reset, miss/hit, conflict, flush, abort, async reset mid-miss and (with ICACHE_STATS_EN) counters.
module tb_fetch_icache_responder;

  logic        CLK;
  logic        nRST;
  logic        imemREN;
  logic [31:0] pc;
  logic        flush;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int exp_hit = 0;
  int exp_miss = 0;
  logic [31:0] sb_q[$];

  fetch_icache_responder #(.SETS(16), .WORD_W(32)) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .imemREN   (imemREN),
    .pc        (pc),
    .flush     (flush),
    .ihit      (ihit),
    .imemload  (imemload),
    .iREN      (iREN),
    .iaddr     (iaddr),
    .iwait     (iwait),
`ifdef ICACHE_STATS_EN
    .hit_count (hit_count),
    .miss_count(miss_count),
`endif
    .iload     (iload)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic sb_check(input string tag);
    if (ihit === 1'b1) begin
      chk({tag, "_sb_nonempty"}, 32'(sb_q.size() > 0), 32'd1);
      if (sb_q.size() > 0) chk({tag, "_data"}, imemload, sb_q.pop_front());
    end
  endtask

  // Entered just after a posedge with the cache in IDLE; leaves just after a posedge back in IDLE.
  task automatic do_miss(input logic [31:0] a, input logic [31:0] d, input int waits, input string tag);
    imemREN = 1'b1; pc = a; iwait = 1'b1; flush = 1'b0;
    #1;
    chk({tag, "_req_ihit"}, 32'(ihit), 32'd0);
    exp_miss++;
    @(posedge CLK); #1;
    chk({tag, "_iren"}, 32'(iREN), 32'd1);
    chk({tag, "_iaddr"}, iaddr, {a[31:2], 2'b00});
    for (int i = 0; i < waits; i++) begin
      chk({tag, "_wait_ihit"}, 32'(ihit), 32'd0);
      @(posedge CLK); #1;
    end
    iwait = 1'b0; iload = d;
    sb_q.push_back(d);
    #1;
    chk({tag, "_fill_ihit"}, 32'(ihit), 32'd1);
    sb_check(tag);
    @(posedge CLK); #1;
    iwait = 1'b1; iload = '0;
  endtask

  task automatic do_hit(input logic [31:0] a, input logic [31:0] d, input string tag);
    imemREN = 1'b1; pc = a; flush = 1'b0;
    sb_q.push_back(d);
    #1;
    chk({tag, "_ihit"}, 32'(ihit), 32'd1);
    chk({tag, "_iren"}, 32'(iREN), 32'd0);
    sb_check(tag);
    exp_hit++;
    @(posedge CLK); #1;
  endtask

  initial begin
    nRST = 1'b0; imemREN = 1'b0; pc = '0; flush = 1'b0; iwait = 1'b1; iload = '0;
    #2;
    chk("rst_ihit", 32'(ihit), 32'd0);
    chk("rst_iren", 32'(iREN), 32'd0);
    chk("rst_iaddr", iaddr, 32'd0);
    chk("rst_imemload", imemload, 32'd0);
    @(negedge CLK); nRST = 1'b1;
    @(posedge CLK); #1;

    // Basic miss with three wait cycles, then zero-latency hit.
    do_miss(32'h0000_0040, 32'h1234_5678, 3, "miss40");
    do_hit (32'h0000_0040, 32'h1234_5678, "hit40");

    // Conflict on index 0: 0x80 evicts 0x40, which then misses again.
    do_miss(32'h0000_0080, 32'hAAAA_0080, 1, "miss80");
    do_miss(32'h0000_0040, 32'h1234_5678, 0, "remiss40");
    do_hit (32'h0000_0042, 32'h1234_5678, "hit40_lowbits");

    // Flush suppresses a would-be hit and invalidates the frame.
    imemREN = 1'b1; pc = 32'h0000_0040; flush = 1'b1;
    #1;
    chk("flush_ihit", 32'(ihit), 32'd0);
    chk("flush_iren", 32'(iREN), 32'd0);
    @(posedge CLK); #1;
    flush = 1'b0;
    do_miss(32'h0000_0040, 32'h1234_5678, 2, "postflush40");

    // Abort: flush during MISS keeps iREN until iwait drops and never signals a hit.
    imemREN = 1'b1; pc = 32'h0000_0100; iwait = 1'b1;
    #1;
    chk("abort_req_ihit", 32'(ihit), 32'd0);
    exp_miss++;
    @(posedge CLK); #1;
    chk("abort_iren", 32'(iREN), 32'd1);
    chk("abort_iaddr", iaddr, 32'h0000_0100);
    flush = 1'b1;
    #1;
    chk("abort_flush_ihit", 32'(ihit), 32'd0);
    @(posedge CLK); #1;
    flush = 1'b0;
    chk("abort_iren_held", 32'(iREN), 32'd1);
    chk("abort_sticky_ihit", 32'(ihit), 32'd0);
    @(posedge CLK); #1;
    iwait = 1'b0; iload = 32'h0BAD_0100;
    #1;
    chk("abort_end_ihit", 32'(ihit), 32'd0);
    chk("abort_end_iren", 32'(iREN), 32'd1);
    @(posedge CLK); #1;
    iwait = 1'b1; imemREN = 1'b0;
    #1;
    chk("abort_idle_iren", 32'(iREN), 32'd0);
    do_miss(32'h0000_0100, 32'h0000_C0DE, 1, "miss100_after_abort");

    // Counter scenario: one miss followed by four hits on 0x40.
    do_miss(32'h0000_0040, 32'h1234_5678, 1, "stats_miss");
    for (int i = 0; i < 4; i++) do_hit(32'h0000_0040, 32'h1234_5678, "stats_hit");
    imemREN = 1'b0;
`ifdef ICACHE_STATS_EN
    #1;
    chk("hit_count", hit_count, 32'(exp_hit));
    chk("miss_count", miss_count, 32'(exp_miss));
`endif
    @(posedge CLK); #1;

    // Asynchronous reset between edges during MISS.
    imemREN = 1'b1; pc = 32'h0000_0080; iwait = 1'b1;
    @(posedge CLK); #1;
    chk("arst_pre_iren", 32'(iREN), 32'd1);
    #2;
    nRST = 1'b0; imemREN = 1'b0;
    #1;
    chk("arst_iren", 32'(iREN), 32'd0);
    chk("arst_ihit", 32'(ihit), 32'd0);
    chk("arst_iaddr", iaddr, 32'd0);
`ifdef ICACHE_STATS_EN
    chk("arst_hit_count", hit_count, 32'd0);
`endif
    @(negedge CLK); nRST = 1'b1;
    @(posedge CLK); #1;
    do_miss(32'h0000_0040, 32'h5555_0040, 0, "arst_miss40");
    imemREN = 1'b0;
    @(posedge CLK); #1;

    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
